// File: rtl/div_arbiter.sv
// Shares one combinational divider between NREQ requesters, with round-robin grants and one tagged response channel.
// Latency: a request accepted in cycle 0 is answered in cycle SETTLE+1, or in cycle 1 when the divisor is zero.
// Backpressure: the response is held while rsp_ready is low, and no new request is granted until it is taken.

// Plain unsigned divider. The b==0 guard only keeps the outputs defined, because the arbiter never uses them in that case.
module div_top #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  // Quotient and remainder; defined values when b is zero
  always_comb begin
    q = '1;
    r = a;
    if (b != '0) begin
      q = a / b;
      r = a % b;
    end
  end

endmodule

module div_arbiter #(
  parameter int WIDTH  = 6,
  parameter int NREQ   = 2,
  parameter int SETTLE = 2,
  parameter int IDW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_q,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_dz,
  output logic                  busy
);

  // cnt counts down from SETTLE-1, so it needs to hold that value and no more
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] div_q, div_r;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a, sel_b;

  // The divider always sees the registered operands, so they stay fixed for the whole settle window
  div_top #(.WIDTH(WIDTH)) u_div (
    .a (a_q),
    .b (b_q),
    .q (div_q),
    .r (div_r)
  );

  // Round-robin search: the first valid requester at or after ptr, wrapping around
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Operands of the winning requester
  always_comb begin
    sel_a = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_b = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  // Grant only in IDLE. The grant is suppressed during reset so that no requester sees a handshake that the block then drops.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_vld && !rst) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state logic and datapath updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          a_d   = sel_a;
          b_d   = sel_b;
          id_d  = gnt_idx;
          ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
          if (sel_b == '0) begin
            // The divider output is not used; the fixed divide-by-zero answer is loaded directly
            quo_d   = '1;
            rem_d   = sel_a;
            dz_d    = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CW'(SETTLE - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          quo_d   = div_q;
          rem_d   = div_r;
          dz_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. A synchronous reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_q     = quo_q;
  assign rsp_r     = rem_q;
  assign rsp_dz    = dz_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter (WIDTH=6, NREQ=2, SETTLE=2).
// Stimulus pushes the expected response; a negedge monitor pops it and compares on each response handshake.
module tb_div_arbiter;

  localparam int W = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [W-1:0]  rsp_q, rsp_r;
  logic          rsp_dz;
  logic          busy;

  typedef struct {
    int id;
    int q;
    int r;
    int dz;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_rsp_cyc = 0;

  div_arbiter #(.WIDTH(W), .NREQ(2), .SETTLE(2), .IDW(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_dz    (rsp_dz),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each response handshake is checked against the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1 && rsp_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id=%0d q=%0d r=%0d, expected no response", rsp_id, rsp_q, rsp_r);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("rsp_id", 32'(rsp_id), e.id);
        chk("rsp_q",  32'(rsp_q),  e.q);
        chk("rsp_r",  32'(rsp_r),  e.r);
        chk("rsp_dz", 32'(rsp_dz), e.dz);
      end
      last_rsp_cyc = cyc;
    end
  end

  // Present one request and hold it until it is accepted; optionally queue its expected response
  task automatic send(input int idx, input int a, input int b, input bit push,
                      input int eid, input int eq, input int er, input int edz,
                      output int acc);
    bit got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    if (push) begin
      e.id = eid; e.q = eq; e.r = er; e.dz = edz;
      expq.push_back(e);
    end
    req_a[idx*W +: W] = W'(a);
    req_b[idx*W +: W] = W'(b);
    req_valid[idx] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain", expq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, hs, accs;
    int acc_c[4];
    exp_t e;

    // Reset with both requesters asserting
    req_valid = 2'b11;
    req_a = {6'd20, 6'd45};
    req_b = {6'd3, 6'd7};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, busy}), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b01;
    e.id = 0; e.q = 6; e.r = 3; e.dz = 0;
    expq.push_back(e);
    @(negedge clk);
    chk("post_reset_regs", 32'({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, busy}), 0);
    chk("first_grant", 32'(req_ready), 32'b01);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    chk("single_latency", last_rsp_cyc - acc, 3);

    // Divide by zero on requester 1: 13/0
    send(1, 13, 0, 1'b1, 1, 63, 13, 1, acc);
    drain();
    chk("dz_latency", last_rsp_cyc - acc, 1);

    // Round robin, both continuously valid, starting at requester 0
    e.id = 0; e.q = 7; e.r = 7; e.dz = 0; expq.push_back(e);
    e.id = 1; e.q = 6; e.r = 2; e.dz = 0; expq.push_back(e);
    e.id = 0; e.q = 7; e.r = 7; e.dz = 0; expq.push_back(e);
    e.id = 1; e.q = 6; e.r = 2; e.dz = 0; expq.push_back(e);
    req_a = {6'd20, 6'd63};
    req_b = {6'd3, 6'd8};
    req_valid = 2'b11;
    accs = 0;
    for (int t = 0; t < 100 && accs < 4; t++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) begin
        acc_c[accs] = cyc;
        accs++;
        if (accs == 4) begin
          @(posedge clk); #1;
          req_valid = 2'b00;
        end
      end
    end
    chk("rr_accepts", accs, 4);
    chk("rr_throughput", acc_c[1] - acc_c[0], 4);
    drain();

    // Backpressure: hold rsp_ready low for 5 cycles of RESP while requester 1 waits
    rsp_ready = 1'b0;
    send(0, 50, 6, 1'b1, 0, 8, 2, 0, acc);
    req_a[W +: W] = 6'd9;
    req_b[W +: W] = 6'd4;
    req_valid[1] = 1'b1;
    e.id = 1; e.q = 2; e.r = 1; e.dz = 0; expq.push_back(e);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int h = 0; h < 5; h++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_hold", 32'({rsp_id, rsp_q, rsp_r, rsp_dz}), 32'({1'b0, 6'd8, 6'd2, 1'b0}));
      chk("bp_no_grant", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      if (h < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    chk("hs_no_grant", 32'(req_ready), 0);
    acc2 = -100;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        acc2 = cyc;
        break;
      end
    end
    chk("grant_after_hs", acc2 - hs, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // Reset during WAIT: the abandoned operation never responds, and ptr returns to 0
    send(0, 30, 5, 1'b0, 0, 0, 0, 0, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abandon_no_rsp", 32'({rsp_valid, busy}), 0);
    end
    @(posedge clk); #1;
    e.id = 0; e.q = 3; e.r = 1; e.dz = 0; expq.push_back(e);
    req_a = {6'd7, 6'd10};
    req_b = {6'd2, 6'd3};
    req_valid = 2'b11;
    @(negedge clk);
    chk("ptr_after_reset", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Exhaustive a in 0..63, b in 1..63 through alternating requesters
    begin
      int k;
      k = 0;
      for (int a = 0; a < 64; a++) begin
        for (int b = 1; b < 64; b++) begin
          send(k % 2, a, b, 1'b1, k % 2, a / b, a % b, 0, acc);
          k++;
        end
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one combinational divider (div_top: a, b -> q, r) between NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on the request side.
- Holds the divider operands stable for a programmable settle time, then registers the quotient and remainder.
- Returns each result on a single tagged response channel with backpressure; divide-by-zero is short-circuited and flagged.

Parameters:
- WIDTH, 6: operand/result width in bits.
- NREQ, 2: number of requesters (>=2).
- SETTLE, 2: cycles operands are held at the divider before the result is captured (>=1).
- IDW, 1: width of the requester id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  dividends; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  divisors, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_q  out  WIDTH  quotient.
- rsp_r  out  WIDTH  remainder.
- rsp_dz  out  1  divide-by-zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, ptr=0, cnt=0, operand registers=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, busy.
  - Reset during WAIT or RESP abandons the operation and never emits its response.
- States: IDLE, WAIT, RESP.
- IDLE, grant:
  - Search req_valid starting at index ptr, ascending, wrapping modulo NREQ.
  - The first set bit g gets req_ready[g]=1 combinationally in the same cycle.
  - No valid request: req_ready=0, stay in IDLE.
- IDLE, accept (req_valid[g] & req_ready[g]), call this cycle 0:
  - Latch a_g and b_g into the operand registers that drive div_top.
  - Latch g as the id.
  - Set ptr = (g+1) mod NREQ.
- IDLE, accept with b_g == 0:
  - The divider result is not used.
  - Load rsp_q = all ones, rsp_r = a_g, rsp_dz = 1; go to RESP.
  - rsp_valid rises in cycle 1.
- IDLE, accept with b_g != 0:
  - Set cnt = SETTLE-1; go to WAIT.
- WAIT:
  - Operand registers are held constant; req_ready=0.
  - While cnt != 0, decrement.
  - When cnt == 0, capture div_top q and r into rsp_q and rsp_r, set rsp_dz = 0, go to RESP.
  - rsp_valid rises in cycle SETTLE+1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q, rsp_r and rsp_dz are stable until rsp_valid & rsp_ready.
  - On that handshake: go to IDLE and drop rsp_valid the next cycle.
  - No new request is accepted in the handshake cycle itself, so at most one operation is in flight.
- Throughput: one result per SETTLE+2 cycles when rsp_ready is tied high, or 2 cycles for divide-by-zero.
- Fairness: with continuously asserted requests, grants rotate 0,1,...,NREQ-1,0,...
  - A valid request is served within NREQ grants.
- Request-side rules:
  - Requesters must hold req_valid and operands until ready.
  - The block samples operands only in the accept cycle.
  - Later operand changes have no effect on an in-flight operation.
- Arithmetic: unsigned; q = a / b and r = a % b, both WIDTH bits, so no overflow is possible.
- rsp_* outputs are registered; req_ready is combinational from state, ptr and req_valid.

Test Plan:
- Reset: assert rst for 2 cycles with req_valid=2'b11 -> every output 0 during and one cycle after; first grant goes to requester 0.
- Single request (WIDTH=6, SETTLE=2): requester 0, a=45, b=7, rsp_ready=1 -> accept in cycle 0; rsp_valid in cycle 3 with q=6, r=3, id=0, dz=0.
- Round robin: both requesters continuously valid (a0=63/b0=8, a1=20/b1=3) -> responses alternate id 0 (q=7, r=7) and id 1 (q=6, r=2), starting with id 0.
- Divide by zero: requester 1, a=13, b=0 -> rsp_valid in cycle 1 with q=63, r=13, dz=1, id=1.
- Backpressure and mid-operation reset:
  - Hold rsp_ready=0 for 5 cycles during RESP -> outputs stable, req_ready stays 0; handshake on cycle 6, then return to IDLE.
  - Separately, assert rst in WAIT -> no response is emitted; ptr returns to 0.
- Exhaustive: every a in 0..63 and b in 1..63 through alternating requesters -> every response matches a/b and a%b with the correct id; 0 errors.
